// File: rtl/l1d_prefetcher.sv
// Next-line/stride L1D prefetcher: turns demand misses into line candidates, fetches them from L2
// and fills L1 while it is idle. Define PF_STRIDE_EN to enable stride detection (default: next-line).
module l1d_prefetcher #(
  parameter int QUEUE_DEPTH = 4,
  parameter int DEGREE      = 2,
  parameter int LINE_BYTES  = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         miss_valid,
  input  logic [31:0]  miss_paddr,
  input  logic         l1_busy,
  input  logic         l1_l2_busy,
  output logic         pf_l2_request,
  output logic [31:0]  pf_l2_addr,
  input  logic         pf_l2_done,
  input  logic [255:0] pf_l2_data,
  output logic         prefetch_valid,
  output logic [31:0]  prefetch_addr,
  output logic [255:0] prefetch_data,
  output logic [7:0]   drop_count
);

  // state   | meaning
  // S_IDLE  | no L2 transaction; pop FIFO head when L2 port is free
  // S_REQ   | pf_l2_request held with stable address until pf_l2_done
  // S_DELIVER | line captured; waiting for L1 idle to strobe the fill
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DELIVER} state_t;

  localparam int          OFF_W     = $clog2(LINE_BYTES);
  localparam int          AW        = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [2:0]  DEG       = 3'(DEGREE);

  state_t state, state_nx;
  logic   pop, capture, deliver;

  logic              gen_busy;
  logic [2:0]        gen_k;
  logic [31:0]       gen_base;
  logic signed [7:0] gen_step;
  logic signed [7:0] new_step;

  logic [31:0]            mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] valid;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   fifo_full, fifo_empty;

  logic [31:0]  step_ext, cand_off, cand;
  logic         page_ok, dup, push, drop;
  logic [255:0] line_buf;

`ifdef PF_STRIDE_EN
  logic [26:0]       last_line;
  logic signed [7:0] last_stride;
  logic [26:0]       miss_line, diff;
  logic              fits8, stride_hit;

  assign miss_line  = miss_paddr[31:5];
  assign diff       = miss_line - last_line;
  // -127..127 only: upper bits all sign, excluding -128
  assign fits8      = (diff[26:7] == '0) || ((diff[26:7] == '1) && (diff[6:0] != 7'd0));
  assign stride_hit = fits8 && (diff != '0) && (diff[7:0] == last_stride);
  assign new_step   = stride_hit ? signed'(diff[7:0]) : 8'sd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_line   <= '0;
      last_stride <= '0;
    end else if (miss_valid) begin
      last_line   <= miss_line;
      last_stride <= signed'(diff[7:0]);
    end
  end
`else
  assign new_step = 8'sd1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_busy <= 1'b0;
      gen_k    <= '0;
      gen_base <= '0;
      gen_step <= 8'sd1;
    end else if (miss_valid) begin
      gen_busy <= 1'b1;
      gen_k    <= 3'd1;
      gen_base <= miss_paddr & LINE_MASK;
      gen_step <= new_step;
    end else if (gen_busy) begin
      if (gen_k == DEG) gen_busy <= 1'b0;
      else              gen_k    <= gen_k + 3'd1;
    end
  end

  assign step_ext = {{24{gen_step[7]}}, gen_step};
  assign cand_off = {29'd0, gen_k} * step_ext;
  assign cand     = gen_base + (cand_off << OFF_W);
  assign page_ok  = (cand[31:12] == gen_base[31:12]);

  always_comb begin
    dup = (state != S_IDLE) && (cand == pf_l2_addr);
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (valid[i] && (mem[i] == cand)) dup = 1'b1;
  end

  assign fifo_full  = &valid;
  assign fifo_empty = ~|valid;
  // full is judged before any same-edge pop
  assign push = gen_busy && page_ok && !dup && !fifo_full;
  assign drop = gen_busy && page_ok && !dup && fifo_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      if (push) begin
        mem[wr_ptr]   <= cand;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             drop_count <= '0;
    else if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    deliver  = 1'b0;
    case (state)
      S_IDLE:    if (!fifo_empty && !l1_l2_busy) begin pop = 1'b1; state_nx = S_REQ; end
      S_REQ:     if (pf_l2_done) begin capture = 1'b1; state_nx = S_DELIVER; end
      S_DELIVER: if (!l1_busy) begin deliver = 1'b1; state_nx = S_IDLE; end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_l2_request  <= 1'b0;
      pf_l2_addr     <= '0;
      line_buf       <= '0;
      prefetch_valid <= 1'b0;
      prefetch_addr  <= '0;
      prefetch_data  <= '0;
    end else begin
      prefetch_valid <= deliver;
      if (pop) begin
        pf_l2_addr    <= mem[rd_ptr];
        pf_l2_request <= 1'b1;
      end
      if (capture) begin
        line_buf      <= pf_l2_data;
        pf_l2_request <= 1'b0;
      end
      if (deliver) begin
        prefetch_addr <= pf_l2_addr;
        prefetch_data <= line_buf;
      end
    end
  end

endmodule

// File: tb/tb_l1d_prefetcher.sv
// Scoreboard bench for l1d_prefetcher: expected L2 reads and L1 fills are queued at stimulus time
// and matched when the DUT produces them; an L2 model answers requests after a fixed latency.
module tb_l1d_prefetcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_valid;
  logic [31:0]  miss_paddr;
  logic         l1_busy;
  logic         l1_l2_busy;
  logic         pf_l2_request;
  logic [31:0]  pf_l2_addr;
  logic         pf_l2_done;
  logic [255:0] pf_l2_data;
  logic         prefetch_valid;
  logic [31:0]  prefetch_addr;
  logic [255:0] prefetch_data;
  logic [7:0]   drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_l2[$];
  logic [31:0] exp_pf[$];

  logic resp_en = 1'b1;
  logic manual_done = 1'b0;
  int   resp_cnt = 0;
  int   resp_lat = 3;

  always #5 clk = ~clk;

  l1d_prefetcher #(.QUEUE_DEPTH(4), .DEGREE(2), .LINE_BYTES(32)) dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_paddr(miss_paddr),
    .l1_busy(l1_busy), .l1_l2_busy(l1_l2_busy),
    .pf_l2_request(pf_l2_request), .pf_l2_addr(pf_l2_addr),
    .pf_l2_done(pf_l2_done), .pf_l2_data(pf_l2_data),
    .prefetch_valid(prefetch_valid), .prefetch_addr(prefetch_addr),
    .prefetch_data(prefetch_data), .drop_count(drop_count)
  );

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'hC3C3_0000, a + 32'd1, a, ~a, a ^ 32'h0F0F_F0F0, a - 32'd1};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_miss(input logic [31:0] a);
    miss_paddr = a;
    miss_valid = 1'b1;
    cycles(1);
    miss_valid = 1'b0;
  endtask

  task automatic expect_pf(input logic [31:0] a);
    exp_l2.push_back(a);
    exp_pf.push_back(a);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_l2.size() != 0 || exp_pf.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_l2", 256'(exp_l2.size()), 256'(0));
    chk("drain_pf", 256'(exp_pf.size()), 256'(0));
    cycles(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_req"},    256'(pf_l2_request),  256'(0));
    chk({tag, "_l2addr"}, 256'(pf_l2_addr),     256'(0));
    chk({tag, "_pv"},     256'(prefetch_valid), 256'(0));
    chk({tag, "_paddr"},  256'(prefetch_addr),  256'(0));
    chk({tag, "_pdata"},  prefetch_data,        256'(0));
    chk({tag, "_drops"},  256'(drop_count),     256'(0));
  endtask

  // L2 model: answers a held request after resp_lat cycles, or a forced stray done
  initial begin
    pf_l2_done = 1'b0;
    pf_l2_data = '0;
    forever begin
      @(posedge clk);
      #1;
      pf_l2_done = 1'b0;
      if (manual_done) begin
        manual_done = 1'b0;
        pf_l2_done  = 1'b1;
        pf_l2_data  = {8{32'hDEAD_BEEF}};
      end else if (resp_en && pf_l2_request) begin
        resp_cnt++;
        if (resp_cnt == resp_lat) begin
          pf_l2_done = 1'b1;
          pf_l2_data = line_of(pf_l2_addr);
          resp_cnt   = 0;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Output monitor
  initial begin
    logic        req_prev = 1'b0;
    logic        pv_prev  = 1'b0;
    logic [31:0] held     = '0;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pf_l2_request && !req_prev) begin
          if (exp_l2.size() == 0) chk("l2_unexpected_req", 256'(pf_l2_request), 256'(0));
          else begin
            a = exp_l2.pop_front();
            chk("l2_addr", 256'(pf_l2_addr), 256'(a));
          end
          held = pf_l2_addr;
        end else if (pf_l2_request && req_prev) begin
          chk("l2_addr_stable", 256'(pf_l2_addr), 256'(held));
        end
        if (prefetch_valid) begin
          chk("pf_width", 256'(pv_prev), 256'(0));
          if (exp_pf.size() == 0) chk("pf_unexpected", 256'(prefetch_valid), 256'(0));
          else begin
            a = exp_pf.pop_front();
            chk("pf_addr", 256'(prefetch_addr), 256'(a));
            chk("pf_data", prefetch_data, line_of(a));
          end
        end
      end
      req_prev = pf_l2_request;
      pv_prev  = prefetch_valid;
    end
  end

  initial begin
    int n;
    reset      = 1'b1;
    miss_valid = 1'b0;
    miss_paddr = '0;
    l1_busy    = 1'b0;
    l1_l2_busy = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    cycles(1);

    // next-line
    expect_pf(32'h0000_1060);
    expect_pf(32'h0000_1080);
    pulse_miss(32'h0000_1044);
    wait_drain(200);
    chk("nl_drops", 256'(drop_count), 256'(0));

    // page boundary: both candidates leave the 4 KiB page
    pulse_miss(32'h0000_1FE0);
    cycles(20);
    chk("page_drops", 256'(drop_count), 256'(0));
    chk("page_req", 256'(pf_l2_request), 256'(0));

    // full / duplicate with L2 port blocked
    l1_l2_busy = 1'b1;
    pulse_miss(32'h0000_0100); cycles(3);
    pulse_miss(32'h0000_0200); cycles(3);
    pulse_miss(32'h0000_0300); cycles(4);
    chk("full_drops", 256'(drop_count), 256'(2));
    pulse_miss(32'h0000_0100); cycles(4);
    chk("dup_drops", 256'(drop_count), 256'(2));
    chk("blocked_req", 256'(pf_l2_request), 256'(0));
    expect_pf(32'h0000_0120);
    expect_pf(32'h0000_0140);
    expect_pf(32'h0000_0220);
    expect_pf(32'h0000_0240);
    l1_l2_busy = 1'b0;
    wait_drain(300);
    cycles(15);

    // DELIVER hold while L1 busy
    l1_busy = 1'b1;
    expect_pf(32'h0000_4020);
    expect_pf(32'h0000_4040);
    pulse_miss(32'h0000_4000);
    n = 0;
    while (!pf_l2_request && n < 30) begin @(negedge clk); n++; end
    chk("hold_req_seen", 256'(pf_l2_request), 256'(1));
    n = 0;
    while (pf_l2_request && n < 30) begin @(negedge clk); n++; end
    chk("hold_req_done", 256'(pf_l2_request), 256'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pv_low", 256'(prefetch_valid), 256'(0));
    end
    @(posedge clk); #1;
    l1_busy = 1'b0;
    @(negedge clk);
    chk("hold_pv_not_yet", 256'(prefetch_valid), 256'(0));
    @(negedge clk);
    chk("hold_pv_pulse", 256'(prefetch_valid), 256'(1));
    wait_drain(200);

    // reset during REQ, then a stray done in IDLE
    resp_en = 1'b0;
    exp_l2.push_back(32'h0000_5020);
    pulse_miss(32'h0000_5000);
    n = 0;
    while (!pf_l2_request && n < 30) begin @(negedge clk); n++; end
    chk("rst_req_seen", 256'(pf_l2_request), 256'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    @(negedge clk);
    manual_done = 1'b1;
    cycles(10);
    check_outputs_zero("midreq");
    chk("midreq_l2q", 256'(exp_l2.size()), 256'(0));
    resp_en = 1'b1;

    // stride
    expect_pf(32'h0000_0020);
    expect_pf(32'h0000_0040);
    pulse_miss(32'h0000_0000);
    wait_drain(200);
    expect_pf(32'h0000_00A0);
    expect_pf(32'h0000_00C0);
    pulse_miss(32'h0000_0080);
    wait_drain(200);
`ifdef PF_STRIDE_EN
    expect_pf(32'h0000_0180);
    expect_pf(32'h0000_0200);
`else
    expect_pf(32'h0000_0120);
    expect_pf(32'h0000_0140);
`endif
    pulse_miss(32'h0000_0100);
    wait_drain(200);
    cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
